seq_muldiv: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the MIPS datapath.
- Executes mult, multu, div, divu, mthi and mtlo, which the single-cycle ALU leaves unimplemented.
- Owns the HI/LO registers and uses a start/busy/done handshake so the pipeline control can stall on busy.
- Sits beside the ALU in EX; mfhi/mflo read hi/lo directly.

---
 rtl/seq_muldiv_if.sv | 27 ++
 rtl/seq_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_seq_muldiv.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/seq_muldiv_if.sv
// Handshake and result bundle for seq_muldiv.
// The pipeline control drives start/op/a/b (master); the unit returns busy/done/dz and HI/LO (slave).
interface seq_muldiv_if #(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, dz, hi, lo
  );

endinterface

// File: rtl/seq_muldiv.sv
// Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
// Handles mult, multu, div, divu (radix-2, one step per cycle) and mthi/mtlo (single edge).
// Optional build macro SEQ_MULDIV_FLUSH_EN adds a flush input that abandons an in-flight op.
module seq_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
`ifdef SEQ_MULDIV_FLUSH_EN
  input logic         flush,
`endif
  seq_muldiv_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;       // product/quotient must be negated
  logic                 rem_neg_q, rem_neg_d; // remainder must be negated
  logic                 dzero_q, dzero_d;   // divisor was zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 flush_act;
  logic                 signed_op;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_sh, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fin;
  logic [WIDTH-1:0]     quo_fin, rem_fin;

`ifdef SEQ_MULDIV_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Operand magnitudes for the accept edge; signed ops take absolute values.
  always_comb begin
    signed_op = ~bus.op[0];
    a_abs     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  // One radix-2 step of each algorithm plus the sign-corrected final results.
  always_comb begin
    // Shift-add: conditionally add multiplicand to the upper half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring divide: shift in the next dividend bit, keep the difference if non-negative.
    div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
    prod_fin = neg_q ? -acc_q : acc_q;
    quo_fin  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // With a zero divisor the remainder is the dividend magnitude, so this restores a.
    rem_fin  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register updates for the IDLE/RUN/FIN sequence.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dzero_d   = dzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            OpMult, OpMultu, OpDiv, OpDivu: begin
              is_div_d  = bus.op[1];
              neg_d     = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rem_neg_d = signed_op & bus.a[WIDTH-1];
              dzero_d   = (bus.b == '0);
              cnt_d     = '0;
              if (bus.op[1]) begin
                acc_d  = {{WIDTH{1'b0}}, a_abs};
                opnd_d = b_abs;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, b_abs};
                opnd_d = a_abs;
              end
              state_d = StRun;
            end
            OpMthi:  hi_d = bus.a;
            OpMtlo:  lo_d = bus.a;
            default: ;
          endcase
        end
      end
      StRun: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
        done_d  = 1'b1;
        dz_d    = is_div_q & dzero_q;
        if (is_div_q) begin
          lo_d = dzero_q ? '1 : quo_fin;
          hi_d = rem_fin;
        end else begin
          {hi_d, lo_d} = prod_fin;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush abandons the op and wins over a simultaneous FIN write.
    if (flush_act && (state_q != StIdle)) begin
      state_d = StIdle;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = dz_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dzero_q   <= dzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv at WIDTH=32.
module tb_seq_muldiv;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
`ifdef SEQ_MULDIV_FLUSH_EN
  logic flush;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_muldiv_if #(.WIDTH(WIDTH)) bus ();

  seq_muldiv #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef SEQ_MULDIV_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble a/b to show they are not re-read.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  // Wait for done; returns the number of posedges from the accept edge to done.
  task automatic wait_done(input string tag, output int lat);
    int k;
    k = 1;
    while (bus.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done seen"}, (bus.done === 1'b1), 1);
    lat = k - 1;
  endtask

  task automatic run_arith(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo, input logic exp_dz);
    int lat;
    issue(op, a, b);
    check({tag, " busy"}, bus.busy, 1);
    wait_done(tag, lat);
    check({tag, " latency"}, lat, WIDTH + 1);
    check({tag, " hi"}, bus.hi, exp_hi);
    check({tag, " lo"}, bus.lo, exp_lo);
    check({tag, " dz"}, bus.dz, exp_dz);
    @(negedge clk);
    check({tag, " done pulse"}, bus.done, 0);
    check({tag, " busy after"}, bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int done_cnt;
    rst       = 1'b1;
`ifdef SEQ_MULDIV_FLUSH_EN
    flush     = 1'b0;
`endif
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset dz", bus.dz, 0);
    check("reset hi", bus.hi, 0);
    check("reset lo", bus.lo, 0);

    run_arith("mult -1*2", 3'b000, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_arith("multu", 3'b001, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    run_arith("mult 7*-3", 3'b000, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_arith("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_arith("div min/-1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_arith("div 7/-2", 3'b010, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
    run_arith("divu 5/0", 3'b011, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 1'b1);

    // mthi in IDLE: single-edge write, no done, dz held.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    check("mthi hi", bus.hi, 32'h1234_5678);
    check("mthi done", bus.done, 0);
    check("mthi busy", bus.busy, 0);
    check("mthi dz held", bus.dz, 1);

    // Reserved op 11x does nothing.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.a     = 32'hCAFE_F00D;
    @(negedge clk);
    bus.start = 1'b0;
    check("nop busy", bus.busy, 0);
    check("nop hi", bus.hi, 32'h1234_5678);
    check("nop lo", bus.lo, 32'hFFFF_FFFF);

    run_arith("divu 9/4", 3'b011, 32'h9, 32'h4, 32'h1, 32'h2, 1'b0);

    // mtlo while busy must be dropped.
    issue(3'b001, 32'h3, 32'h5);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b101;
    bus.a     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    check("mtlo busy ignored", bus.lo, 32'h2);
    check("mtlo busy still", bus.busy, 1);
    wait_done("multu 3*5", lat);
    check("multu 3*5 hi", bus.hi, 32'h0);
    check("multu 3*5 lo", bus.lo, 32'hF);

    run_arith("div -7/0", 3'b010, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

`ifdef SEQ_MULDIV_FLUSH_EN
    issue(3'b010, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", bus.busy, 0);
    check("flush hi kept", bus.hi, 32'hFFFF_FFF9);
    check("flush lo kept", bus.lo, 32'hFFFF_FFFF);
    check("flush dz kept", bus.dz, 1);
    done_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("flush no done", done_cnt, 0);
`endif

    // Reset 10 cycles into a div discards the op.
    issue(3'b010, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", bus.busy, 0);
    check("rst hi", bus.hi, 0);
    check("rst lo", bus.lo, 0);
    check("rst dz", bus.dz, 0);
    done_cnt = (bus.done === 1'b1) ? 1 : 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("rst no done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
